// File: rtl/dvs_aer_event_bus_bridge.sv
// dvs_aer_event_bus_bridge
//   Receives 4-phase AER address words from a DVS camera, builds timestamped
//   events {x, y, polarity, timestamp}, buffers them in a circular queue and
//   writes them to the shared FIFO bus with a req/grant/write-enable protocol.
//
// Ports
//   clk, rst     : single clock, synchronous active-high reset
//   aer, xsel    : AER data word and word type (0 = Y/row word, 1 = X word)
//   req / ack    : AER 4-phase handshake (req is asynchronous)
//   time_us      : free-running microsecond time, sampled when an event is built
//   fifo_grant   : bus grant, sampled each cycle
//   fifo_req     : bus request, fifo_wr_en: one-cycle write strobe
//   fifo_event   : event written to the bus, holds between writes
//   queue_level  : queue occupancy, drop_count: saturating lost-event counter
//
// Configuration macro DVS_AER_BACKPRESSURE_EN
//   defined   : an X word hitting a full queue stalls the handshake (no loss)
//   undefined : the event is discarded and drop_count increments
module dvs_aer_event_bus_bridge #(
  parameter int X_BITS      = 8,
  parameter int Y_BITS      = 8,
  parameter int TS_BITS     = 32,
  parameter int AER_BITS    = 10,
  parameter int DEPTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_BITS    = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [AER_BITS-1:0]              aer,
  input  logic                             xsel,
  input  logic                             req,
  input  logic [TS_BITS-1:0]               time_us,
  input  logic                             fifo_grant,
  output logic                             ack,
  output logic                             fifo_req,
  output logic                             fifo_wr_en,
  output logic [X_BITS+Y_BITS+TS_BITS:0]   fifo_event,
  output logic [$clog2(DEPTH):0]           queue_level,
  output logic [CNT_BITS-1:0]              drop_count
);

  localparam int EV_W  = X_BITS + Y_BITS + 1 + TS_BITS;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_LATCH = 2'd1,
    RX_ACK   = 2'd2
  } rx_state_e;

  rx_state_e               state_q, state_d;
  logic [SYNC_STAGES-1:0]  req_sync_q;
  logic                    req_s;
  logic [Y_BITS-1:0]       row_q, row_d;
  logic [PTR_W-1:0]        head_q, head_d, tail_q, tail_d;
  logic [LVL_W-1:0]        count_q, count_d;
  logic                    wr_en_q, fifo_req_q, fifo_req_d;
  logic [EV_W-1:0]         event_q, event_d;
  logic [CNT_BITS-1:0]     drop_q, drop_d;
  logic [EV_W-1:0]         mem_q [DEPTH];
  logic [EV_W-1:0]         new_event;
  logic                    push, pop, drop, full;
  logic                    unused_aer;

  // Upper AER bits beyond the X/Y fields carry no information for this camera.
  assign unused_aer = ^aer;

  // Multi-flop synchronizer for the asynchronous AER request.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_sync_q <= '0;
    end else begin
      req_sync_q <= {req_sync_q[SYNC_STAGES-2:0], req};
    end
  end

  assign req_s = req_sync_q[SYNC_STAGES-1];

  // Receiver next-state logic plus queue bookkeeping. A pop is a grant seen
  // while our request is up; a push into a full queue is allowed only when
  // that same cycle also pops, so occupancy can never exceed DEPTH.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    push      = 1'b0;
    drop      = 1'b0;
    pop       = fifo_grant && fifo_req_q;
    full      = (count_q == LVL_W'(DEPTH));
    new_event = {aer[X_BITS:1], row_q, aer[0], time_us};

    unique case (state_q)
      RX_IDLE: begin
        if (req_s) state_d = RX_LATCH;
      end
      RX_LATCH: begin
        if (!xsel) begin
          row_d   = aer[Y_BITS-1:0];
          state_d = RX_ACK;
        end else if (!full || pop) begin
          push    = 1'b1;
          state_d = RX_ACK;
        end else begin
`ifdef DVS_AER_BACKPRESSURE_EN
          // Hold the camera off (ack low) and retry the push next cycle.
          state_d = RX_LATCH;
`else
          drop    = 1'b1;
          state_d = RX_ACK;
`endif
        end
      end
      RX_ACK: begin
        if (!req_s) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase

    head_d  = pop  ? head_q + PTR_W'(1) : head_q;
    tail_d  = push ? tail_q + PTR_W'(1) : tail_q;
    event_d = pop  ? mem_q[head_q] : event_q;

    unique case ({push, pop})
      2'b10:   count_d = count_q + LVL_W'(1);
      2'b01:   count_d = count_q - LVL_W'(1);
      default: count_d = count_q;
    endcase

    // Request drops for the write-strobe cycle so grants cannot double-pop.
    fifo_req_d = (count_d != '0) && !pop;

    drop_d = drop_q;
    if (drop && (drop_q != '1)) drop_d = drop_q + CNT_BITS'(1);
  end

  // State, pointer and bus-side registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RX_IDLE;
      row_q      <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      wr_en_q    <= 1'b0;
      fifo_req_q <= 1'b0;
      event_q    <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      wr_en_q    <= pop;
      fifo_req_q <= fifo_req_d;
      event_q    <= event_d;
      drop_q     <= drop_d;
    end
  end

  // Queue storage needs no reset: the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[tail_q] <= new_event;
  end

  assign ack         = (state_q == RX_ACK);
  assign fifo_req    = fifo_req_q;
  assign fifo_wr_en  = wr_en_q;
  assign fifo_event  = event_q;
  assign queue_level = count_q;
  assign drop_count  = drop_q;

endmodule

// File: tb/tb_dvs_aer_event_bus_bridge.sv
// tb_dvs_aer_event_bus_bridge
//   Directed and randomized stimulus for dvs_aer_event_bus_bridge. Expected
//   events come from a sequence-level model: a row register, a bounded event
//   queue and an expected-write list, built straight from the AER word rules.
module tb_dvs_aer_event_bus_bridge;

  localparam int X_BITS      = 8;
  localparam int Y_BITS      = 8;
  localparam int TS_BITS     = 32;
  localparam int AER_BITS    = 10;
  localparam int DEPTH       = 8;
  localparam int SYNC_STAGES = 2;
  localparam int CNT_BITS    = 16;
  localparam int EV_W        = X_BITS + Y_BITS + 1 + TS_BITS;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [AER_BITS-1:0]  aer = '0;
  logic                 xsel = 1'b0;
  logic                 req = 1'b0;
  logic [TS_BITS-1:0]   time_us = '0;
  logic                 fifo_grant = 1'b0;
  logic                 ack;
  logic                 fifo_req;
  logic                 fifo_wr_en;
  logic [EV_W-1:0]      fifo_event;
  logic [$clog2(DEPTH):0] queue_level;
  logic [CNT_BITS-1:0]  drop_count;

  dvs_aer_event_bus_bridge #(
    .X_BITS(X_BITS), .Y_BITS(Y_BITS), .TS_BITS(TS_BITS), .AER_BITS(AER_BITS),
    .DEPTH(DEPTH), .SYNC_STAGES(SYNC_STAGES), .CNT_BITS(CNT_BITS)
  ) dut (
    .clk(clk), .rst(rst), .aer(aer), .xsel(xsel), .req(req),
    .time_us(time_us), .fifo_grant(fifo_grant), .ack(ack),
    .fifo_req(fifo_req), .fifo_wr_en(fifo_wr_en), .fifo_event(fifo_event),
    .queue_level(queue_level), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total = 0;
  int failed = 0;
  int cyc = 0;
  int protoErr = 0;
  logic prevWr = 1'b0;
  int rowModel = 0;
  int dropModel = 0;
  logic [EV_W-1:0] modelQ[$];
  logic [EV_W-1:0] wrExp[$];
  logic [EV_W-1:0] gotQ[$];
  int gotCyc[$];

  // Cycle counter used to measure write spacing.
  always @(posedge clk) cyc <= cyc + 1;

  // Bus monitor: collect every write and flag protocol violations
  // (request high during a write, or two strobes in a row).
  always @(negedge clk) begin
    if (fifo_wr_en === 1'b1) begin
      gotQ.push_back(fifo_event);
      gotCyc.push_back(cyc);
      if (fifo_req !== 1'b0) protoErr++;
      if (prevWr === 1'b1) protoErr++;
    end
    prevWr = fifo_wr_en;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    total++;
    assert (observed === expected) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [EV_W-1:0] mkEvent(input int a, input int row,
                                               input logic [31:0] ts);
    longint v;
    v = longint'((a >> 1) % (1 << X_BITS));
    v = v * (1 << Y_BITS) + longint'(row);
    v = v * 2 + longint'(a % 2);
    v = (v << TS_BITS) | longint'(ts);
    return EV_W'(v);
  endfunction

  task automatic modelX(input int a, input logic [31:0] ts);
    if (modelQ.size() < DEPTH) modelQ.push_back(mkEvent(a, rowModel, ts));
    else if (dropModel < (1 << CNT_BITS) - 1) dropModel++;
  endtask

  task automatic clearModel();
    modelQ.delete();
    wrExp.delete();
    gotQ.delete();
    gotCyc.delete();
    rowModel = 0;
    dropModel = 0;
  endtask

  task automatic startWord(input logic xs, input int a, input logic [31:0] ts);
    @(negedge clk);
    xsel = xs;
    aer = AER_BITS'(a);
    time_us = ts;
    req = 1'b1;
  endtask

  task automatic waitAckHigh(output int edges, output bit ok);
    edges = 0;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(posedge clk);
      #1;
      edges++;
      if (ack === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic releaseWord(output int edges, output bit ok);
    @(negedge clk);
    req = 1'b0;
    edges = 0;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(posedge clk);
      #1;
      edges++;
      if (ack === 1'b0) ok = 1'b1;
    end
  endtask

  // One full 4-phase word; updates the model when the handshake completes.
  task automatic applyStimulus(input string tag, input logic xs, input int a,
                               input logic [31:0] ts);
    int e;
    bit ok;
    startWord(xs, a, ts);
    waitAckHigh(e, ok);
    checkOutput({tag, " ack rise"}, 64'(ok), 64'd1);
    releaseWord(e, ok);
    checkOutput({tag, " ack fall"}, 64'(ok), 64'd1);
    if (xs) modelX(a, ts);
    else rowModel = a % (1 << Y_BITS);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    req = 1'b0;
    fifo_grant = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    clearModel();
  endtask

  // Hold grant until the queue empties, then compare writes with the model.
  task automatic drain(input string tag);
    int start;
    bit done;
    start = gotQ.size();
    done = 1'b0;
    @(negedge clk);
    fifo_grant = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (queue_level == 0 && fifo_wr_en === 1'b0) done = 1'b1;
    end
    fifo_grant = 1'b0;
    checkOutput({tag, " drained"}, 64'(done), 64'd1);
    while (modelQ.size() > 0) wrExp.push_back(modelQ.pop_front());
    checkOutput({tag, " write count"}, 64'(gotQ.size()), 64'(wrExp.size()));
    for (int i = 0; i < wrExp.size(); i++)
      if (i < gotQ.size())
        checkOutput($sformatf("%s event%0d", tag, i), 64'(gotQ[i]), 64'(wrExp[i]));
    for (int i = start + 1; i < gotQ.size(); i++)
      checkOutput($sformatf("%s spacing%0d", tag, i), 64'(gotCyc[i] - gotCyc[i-1]), 64'd2);
    gotQ.delete();
    gotCyc.delete();
    wrExp.delete();
  endtask

  initial begin
    int e;
    bit ok;
    int a;
    int n;
    logic [31:0] ts;

    // Reset values.
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkOutput("rst ack", 64'(ack), 64'd0);
    checkOutput("rst fifo_req", 64'(fifo_req), 64'd0);
    checkOutput("rst wr_en", 64'(fifo_wr_en), 64'd0);
    checkOutput("rst event", 64'(fifo_event), 64'd0);
    checkOutput("rst level", 64'(queue_level), 64'd0);
    checkOutput("rst drops", 64'(drop_count), 64'd0);

    // Single event with handshake latency measurement.
    startWord(1'b0, 5, 32'd1000);
    waitAckHigh(e, ok);
    checkOutput("t1 ack rise edges", 64'(e), 64'(SYNC_STAGES + 2));
    releaseWord(e, ok);
    checkOutput("t1 ack fall edges", 64'(e), 64'(SYNC_STAGES + 1));
    rowModel = 5;
    applyStimulus("t1 x", 1'b1, 'h0C7, 32'd1000);
    checkOutput("t1 level", 64'(queue_level), 64'd1);
    checkOutput("t1 fifo_req", 64'(fifo_req), 64'd1);
    drain("t1");
    checkOutput("t1 event hold", 64'(fifo_event),
                64'({8'h63, 8'h05, 1'b1, 32'd1000}));

    // X word before any Y word uses row 0.
    doReset();
    applyStimulus("t2 x", 1'b1, 'h003, 32'd77);
    drain("t2");

    // Row burst: three X words on one row, then drain at full rate.
    applyStimulus("t3 y", 1'b0, 2, 32'd0);
    for (int i = 0; i < 3; i++)
      applyStimulus("t3 x", 1'b1, int'($urandom_range(0, 1023)), $urandom);
    checkOutput("t3 level", 64'(queue_level), 64'd3);
    checkOutput("t3 fifo_req", 64'(fifo_req), 64'd1);
    drain("t3");
    checkOutput("t3 level empty", 64'(queue_level), 64'd0);

    // Overflow policy.
    doReset();
`ifdef DVS_AER_BACKPRESSURE_EN
    for (int i = 0; i < DEPTH; i++)
      applyStimulus("t4 x", 1'b1, int'($urandom_range(0, 1023)), $urandom);
    a = int'($urandom_range(0, 1023));
    ts = $urandom;
    startWord(1'b1, a, ts);
    waitAckHigh(e, ok);
    checkOutput("t4 bp ack withheld", 64'(ok), 64'd0);
    checkOutput("t4 bp level", 64'(queue_level), 64'(DEPTH));
    checkOutput("t4 bp drops", 64'(drop_count), 64'd0);
    @(negedge clk);
    fifo_grant = 1'b1;
    @(negedge clk);
    fifo_grant = 1'b0;
    wrExp.push_back(modelQ.pop_front());
    modelX(a, ts);
    waitAckHigh(e, ok);
    checkOutput("t4 bp ack after pop", 64'(ok), 64'd1);
    releaseWord(e, ok);
    checkOutput("t4 bp ack fall", 64'(ok), 64'd1);
    checkOutput("t4 bp level after", 64'(queue_level), 64'(DEPTH));
`else
    for (int i = 0; i < DEPTH + 2; i++)
      applyStimulus("t4 x", 1'b1, int'($urandom_range(0, 1023)), $urandom);
    checkOutput("t4 level", 64'(queue_level), 64'(DEPTH));
    checkOutput("t4 drops", 64'(drop_count), 64'(dropModel));
    checkOutput("t4 drops abs", 64'(drop_count), 64'd2);
`endif
    drain("t4");

    // Push and pop in the same cycle while full.
    doReset();
    applyStimulus("t5 y", 1'b0, int'($urandom_range(0, 255)), 32'd0);
    for (int i = 0; i < DEPTH; i++)
      applyStimulus("t5 x", 1'b1, int'($urandom_range(0, 1023)), $urandom);
    a = int'($urandom_range(0, 1023));
    ts = $urandom;
    startWord(1'b1, a, ts);
    repeat (SYNC_STAGES + 1) @(negedge clk);
    fifo_grant = 1'b1;
    @(negedge clk);
    fifo_grant = 1'b0;
    wrExp.push_back(modelQ.pop_front());
    modelX(a, ts);
    checkOutput("t5 ack", 64'(ack), 64'd1);
    checkOutput("t5 level", 64'(queue_level), 64'(DEPTH));
    checkOutput("t5 drops", 64'(drop_count), 64'd0);
    releaseWord(e, ok);
    checkOutput("t5 ack fall", 64'(ok), 64'd1);
    drain("t5");

    // Reset in the middle of a handshake with events queued.
    doReset();
    for (int i = 0; i < 3; i++)
      applyStimulus("t6 x", 1'b1, int'($urandom_range(0, 1023)), $urandom);
    a = int'($urandom_range(0, 1023));
    ts = $urandom;
    startWord(1'b1, a, ts);
    waitAckHigh(e, ok);
    checkOutput("t6 ack before rst", 64'(ok), 64'd1);
    checkOutput("t6 level before rst", 64'(queue_level), 64'd4);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("t6 ack", 64'(ack), 64'd0);
    checkOutput("t6 fifo_req", 64'(fifo_req), 64'd0);
    checkOutput("t6 wr_en", 64'(fifo_wr_en), 64'd0);
    checkOutput("t6 event", 64'(fifo_event), 64'd0);
    checkOutput("t6 level", 64'(queue_level), 64'd0);
    checkOutput("t6 drops", 64'(drop_count), 64'd0);
    rst = 1'b0;
    clearModel();
    waitAckHigh(e, ok);
    checkOutput("t6 ack reassert edges", 64'(e), 64'(SYNC_STAGES + 2));
    modelX(a, ts);
    releaseWord(e, ok);
    checkOutput("t6 ack fall", 64'(ok), 64'd1);
    checkOutput("t6 level after", 64'(queue_level), 64'd1);
    drain("t6");

    // Randomized row bursts.
    for (int b = 0; b < 4; b++) begin
      applyStimulus("rnd y", 1'b0, int'($urandom_range(0, 1023)), 32'd0);
      n = int'($urandom_range(1, 5));
      for (int i = 0; i < n; i++)
        applyStimulus("rnd x", 1'b1, int'($urandom_range(0, 1023)), $urandom);
      checkOutput($sformatf("rnd%0d level", b), 64'(queue_level), 64'(modelQ.size()));
      checkOutput($sformatf("rnd%0d drops", b), 64'(drop_count), 64'(dropModel));
      drain($sformatf("rnd%0d", b));
    end

    checkOutput("bus protocol", 64'(protoErr), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/dvs_aer_event_bus_bridge.md
# dvs_aer_event_bus_bridge

- Receives address-event words from a DVS camera over a 4-phase AER handshake and assembles them into timestamped events.
- Buffers events in a parametrised on-chip queue, then writes them to the shared FIFO bus through a req/grant/write-enable protocol.
- Successor to the single-event AER-to-event interface. Events that arrive before the bus grant are queued instead of overwritten. Queue overflow is handled by a compile-time policy.

## Interface
Parameters:
- X_BITS, 8, width of the X address.
- Y_BITS, 8, width of the Y address.
- TS_BITS, 32, timestamp width in microseconds.
- AER_BITS, 10, AER data bus width. Must be ≥ max(Y_BITS, X_BITS+1).
- DEPTH, 8, queue depth. Power of two, ≥ 2.
- SYNC_STAGES, 2, synchronizer flops on `req`. Must be ≥ 2.
- CNT_BITS, 16, width of the drop counter.

Ports:
- `clk` input 1: the single clock.
- `rst` input 1: synchronous, active-high reset.
- `aer` input AER_BITS: AER data. Stable while `req` is high.
- `xsel` input 1: 0 means a Y (row) word, 1 means an X word.
- `req` input 1: AER request, active-high, asynchronous.
- `time_us` input TS_BITS: free-running microsecond time.
- `fifo_grant` input 1: bus grant, sampled each cycle.
- `ack` output 1: AER acknowledge.
- `fifo_req` output 1: bus request.
- `fifo_wr_en` output 1: bus write strobe, one cycle wide.
- `fifo_event` output X_BITS+Y_BITS+1+TS_BITS: event packed MSB→LSB as {x, y, polarity, timestamp}.
- `queue_level` output $clog2(DEPTH)+1: current queue occupancy.
- `drop_count` output CNT_BITS: number of dropped events, saturating.

## Operation
Synchronization:
- `req` passes through SYNC_STAGES flops to give `req_s`.
- `aer` and `xsel` are sampled only in RX_LATCH; they are guaranteed stable by the handshake.

Receiver FSM:
- RX_IDLE: `ack`=0. Go to RX_LATCH when `req_s`=1.
- RX_LATCH: sample `aer` and `xsel`.
  - Y word (`xsel`=0): `row` ← aer[Y_BITS-1:0]. Go to RX_ACK.
  - X word (`xsel`=1): build the event {aer[X_BITS:1], row, aer[0], time_us}, with `time_us` sampled in this cycle. Push it if possible (see the full-queue rules), then go to RX_ACK.
- RX_ACK: `ack`=1. Return to RX_IDLE when `req_s`=0; `ack` is 0 from that next cycle.

Address and ordering rules:
- `row` resets to 0. An X word received before any Y word uses y=0.
- Multiple X words may share one Y word (row-burst mode).

Queue:
- Circular buffer with DEPTH entries plus an occupancy counter.
- Push and pop in the same cycle are both performed; occupancy is unchanged.
- A push into a full queue is legal in a cycle where a pop also occurs.

Bus side:
- `fifo_req` = (queue_level ≠ 0) && !`fifo_wr_en`, driven by registered logic.
- `fifo_grant`=1 while `fifo_req`=1 causes, in the next cycle, `fifo_wr_en`=1 with `fifo_event` = head entry, and the head is popped.
- `fifo_grant` while `fifo_req`=0 is ignored.
- `fifo_event` holds its last value when `fifo_wr_en`=0.

## Timing
Reset (`rst`=1 at a clk edge):
- `ack`, `fifo_req`, `fifo_wr_en`, `fifo_event`, `queue_level`, `drop_count` = 0.
- FSM returns to RX_IDLE, `row`=0, queue emptied.
- A `req` still high after reset is treated as a fresh word; the camera holds data until `ack`.

Latencies:
- `req` high at the synchronizer input → `ack` high after SYNC_STAGES+2 edges.
- `req` low → `ack` low after SYNC_STAGES+1 edges.
- X-word push in RX_LATCH → `queue_level` increments and `fifo_req` rises at the next edge.
- Grant → write: `fifo_wr_en` is high one cycle after the grant. `fifo_req` is low during the `fifo_wr_en` cycle.
- Back-to-back writes are possible every 2 cycles.

## Configuration
Macro `DVS_AER_BACKPRESSURE_EN`:
- Defined:
  - An X word arriving at a full queue with no pop in that cycle makes the FSM stay in RX_LATCH. `ack` stays low.
  - The FSM re-evaluates each cycle. `time_us` is sampled in the cycle the push succeeds.
  - No events are lost; `drop_count` stays 0.
- Undefined:
  - The same case discards the event and increments `drop_count`, saturating at all-ones.
  - The FSM proceeds to RX_ACK without stalling.

## Test plan
- Y=5, then X word aer=0x0C7 (x=0x63, p=1) at time_us=1000, grant given immediately → one `fifo_wr_en` with event {0x63, 0x05, 1, 1000}. `ack` cycle counts match the Timing section.
- X word sent first after reset, aer=0x003 → event has y=0, x=1, p=1.
- Y=2 followed by 3 X words, no grant → `queue_level`=3 and `fifo_req`=1. Then grant held high → 3 writes in FIFO order, one every 2 cycles, `queue_level` reaches 0.
- DEPTH=8, 10 X words sent with no grant, macro undefined → `queue_level`=8, `drop_count`=2. Macro defined → 9th `ack` is withheld until one grant pops an entry.
- Push and grant-pop land in the same cycle at full → `queue_level` stays 8 and no drop occurs.
- `rst` pulsed while in RX_ACK with 4 events queued → all outputs 0 at the next edge. Holding `req` high → `ack` reasserts SYNC_STAGES+2 edges after `rst` falls.
